i_decode: RTL

Instruction-decode stage of the 5-stage MIPS-subset pipeline, directly downstream of `i_fetch`. It consumes the IF/ID latch outputs `IF_ID_instruction` and `IF_ID_npc`, reads a 32×32 register file, sign-extends the immediate and decodes control. It registers everything into the ID/EX latch. It also owns load-use hazard detection, producing the stall that freezes PC and IF/ID, and it accepts the branch-taken flush from EX/MEM.

---
 rtl/i_decode_pkg.sv | 40 ++++
 rtl/i_decode_if.sv | 27 ++
 rtl/i_decode_register_file.sv | 44 ++++
 rtl/i_decode.sv | 77 +++++++
 4 files changed

// File: rtl/i_decode_pkg.sv
// Shared opcode encodings, control-vector layout and the control ROM
// used by the decode stage.
package i_decode_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef struct packed {
        logic [3:0] ex;   // {RegDst, ALUOp[1:0], ALUSrc}
        logic [2:0] m;    // {Branch, MemRead, MemWrite}
        logic [1:0] wb;   // {RegWrite, MemtoReg}
    } ctrl_t;

    localparam ctrl_t CTRL_NONE  = '0;
    localparam ctrl_t CTRL_RTYPE = '{ex: 4'b1100, m: 3'b000, wb: 2'b10};
    localparam ctrl_t CTRL_LW    = '{ex: 4'b0001, m: 3'b010, wb: 2'b11};
    localparam ctrl_t CTRL_SW    = '{ex: 4'b0001, m: 3'b001, wb: 2'b00};
    localparam ctrl_t CTRL_BEQ   = '{ex: 4'b0010, m: 3'b100, wb: 2'b00};

    // The all-zero word is a nop and must not decode as an R-type.
    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t c;
        c = CTRL_NONE;
        if (instr != '0) begin
            case (instr[31:26])
                OP_RTYPE: c = CTRL_RTYPE;
                OP_LW:    c = CTRL_LW;
                OP_SW:    c = CTRL_SW;
                OP_BEQ:   c = CTRL_BEQ;
                default:  c = CTRL_NONE;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/i_decode_if.sv
// ID/EX pipeline latch bundle: decode drives it, execute consumes it.
interface i_decode_if;

    logic [1:0]  ID_EX_wb;
    logic [2:0]  ID_EX_m;
    logic [3:0]  ID_EX_ex;
    logic [31:0] ID_EX_npc;
    logic [31:0] ID_EX_readdat1;
    logic [31:0] ID_EX_readdat2;
    logic [31:0] ID_EX_sign_ext;
    logic [4:0]  ID_EX_rs;
    logic [4:0]  ID_EX_rt;
    logic [4:0]  ID_EX_rd;

    modport master (
        output ID_EX_wb, ID_EX_m, ID_EX_ex, ID_EX_npc,
               ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext,
               ID_EX_rs, ID_EX_rt, ID_EX_rd
    );

    modport slave (
        input  ID_EX_wb, ID_EX_m, ID_EX_ex, ID_EX_npc,
               ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext,
               ID_EX_rs, ID_EX_rt, ID_EX_rd
    );

endinterface

// File: rtl/i_decode_register_file.sv
// 32x32 register file: two async read ports with write-through bypass,
// one synchronous write port, r0 hardwired to zero.
module register_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    input  logic        reg_write,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write && write_reg != '0) begin
            regs[write_reg] <= write_data;
        end
    end

    // Bypass lets a same-cycle writeback reach the ID/EX latch.
    always_comb begin
        read_data1 = regs[read_reg1];
        if (read_reg1 == '0)
            read_data1 = '0;
        else if (reg_write && write_reg == read_reg1)
            read_data1 = write_data;
    end

    always_comb begin
        read_data2 = regs[read_reg2];
        if (read_reg2 == '0)
            read_data2 = '0;
        else if (reg_write && write_reg == read_reg2)
            read_data2 = write_data;
    end

endmodule

// File: rtl/i_decode.sv
// Instruction-decode stage: field/control decode, register read,
// load-use hazard detection and the ID/EX pipeline latch.
module i_decode
    import i_decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IF_ID_instruction,
    input  logic [31:0] IF_ID_npc,
    input  logic        MEM_WB_reg_write,
    input  logic [4:0]  MEM_WB_rd,
    input  logic [31:0] MEM_WB_write_data,
    input  logic        EX_MEM_PC_Source,
    output logic        stall,
    i_decode_if.master  id_ex
);

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] sign_ext;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    ctrl_t       ctrl;
    logic        bubble;

    assign rs       = IF_ID_instruction[25:21];
    assign rt       = IF_ID_instruction[20:16];
    assign rd       = IF_ID_instruction[15:11];
    assign sign_ext = {{16{IF_ID_instruction[15]}}, IF_ID_instruction[15:0]};
    assign ctrl     = decode_ctrl(IF_ID_instruction);

    register_file u_register_file (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_reg1  (rs),
        .read_reg2  (rt),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .reg_write  (MEM_WB_reg_write),
        .write_reg  (MEM_WB_rd),
        .write_data (MEM_WB_write_data)
    );

    // A taken branch squashes this instruction, so it cannot also stall.
    assign stall = id_ex.ID_EX_m[1] && (id_ex.ID_EX_rt != '0) &&
                   ((id_ex.ID_EX_rt == rs) || (id_ex.ID_EX_rt == rt)) &&
                   !EX_MEM_PC_Source;
    assign bubble = stall || EX_MEM_PC_Source;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex.ID_EX_wb       <= '0;
            id_ex.ID_EX_m        <= '0;
            id_ex.ID_EX_ex       <= '0;
            id_ex.ID_EX_npc      <= '0;
            id_ex.ID_EX_readdat1 <= '0;
            id_ex.ID_EX_readdat2 <= '0;
            id_ex.ID_EX_sign_ext <= '0;
            id_ex.ID_EX_rs       <= '0;
            id_ex.ID_EX_rt       <= '0;
            id_ex.ID_EX_rd       <= '0;
        end else begin
            id_ex.ID_EX_wb       <= bubble ? '0 : ctrl.wb;
            id_ex.ID_EX_m        <= bubble ? '0 : ctrl.m;
            id_ex.ID_EX_ex       <= bubble ? '0 : ctrl.ex;
            id_ex.ID_EX_npc      <= IF_ID_npc;
            id_ex.ID_EX_readdat1 <= read_data1;
            id_ex.ID_EX_readdat2 <= read_data2;
            id_ex.ID_EX_sign_ext <= sign_ext;
            id_ex.ID_EX_rs       <= rs;
            id_ex.ID_EX_rt       <= rt;
            id_ex.ID_EX_rd       <= rd;
        end
    end

endmodule
